// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single external memory port between NUM_REQ on-die requesters.
//   Round-robin arbitration, one outstanding access, fixed-latency memory.
//   FSM: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE -> IDLE. All outputs registered.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req/req_we           per-requester request level and write flag
//   req_addr/req_wdata   packed per-requester address / write data
//   gnt/done             one-hot single-cycle accept / complete pulses
//   rdata                read data, valid in the done cycle of a read
//   mem_addr/mem_wdata   memory address and write data
//   mem_data_oe          enable for the Die-level mem_data driver
//   mem_rdata            data sampled from mem_data
//   mrd/mwr              memory read / write strobes
module mem_bus_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_data_oe,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      mrd,
  output logic                      mwr
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned PW1   = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t               r_state,  w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [PTR_W-1:0]     r_rr_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]     r_winner, w_winner_nxt;
  logic                 r_we,     w_we_nxt;
  logic [NUM_REQ-1:0]   r_gnt,    w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_done,   w_done_nxt;
  logic                 r_mrd,    w_mrd_nxt;
  logic                 r_mwr,    w_mwr_nxt;
  logic                 r_oe,     w_oe_nxt;
  logic [ADDR_W-1:0]    r_addr,   w_addr_nxt;
  logic [DATA_W-1:0]    r_wdata,  w_wdata_nxt;
  logic [DATA_W-1:0]    r_rdata,  w_rdata_nxt;

  logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    w_wdata_arr [NUM_REQ];
  logic [PTR_W-1:0]     w_sel;
  logic                 w_found;
  logic [PW1-1:0]       w_cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first set request wins.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + PW1'(i);
      if (w_cand >= PW1'(NUM_REQ)) w_cand = w_cand - PW1'(NUM_REQ);
      if (!w_found && req[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_rr_ptr;
    w_winner_nxt = r_winner;
    w_we_nxt     = r_we;
    w_gnt_nxt    = '0;
    w_done_nxt   = '0;
    w_mrd_nxt    = 1'b0;
    w_mwr_nxt    = 1'b0;
    w_oe_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_winner_nxt     = w_sel;
          w_we_nxt         = req_we[w_sel];
          w_addr_nxt       = w_addr_arr[w_sel];
          w_wdata_nxt      = w_wdata_arr[w_sel];
          w_gnt_nxt[w_sel] = 1'b1;
          w_mrd_nxt        = ~req_we[w_sel];
          w_mwr_nxt        = req_we[w_sel];
          w_oe_nxt         = req_we[w_sel];
          w_cnt_nxt        = '0;
          w_state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == CNT_W'(WAIT_CYCLES)) begin
          // Last strobe cycle: strobes fall with done, read data captured.
          w_done_nxt[r_winner] = 1'b1;
          if (!r_we) w_rdata_nxt = mem_rdata;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_mrd_nxt = ~r_we;
          w_mwr_nxt = r_we;
          w_oe_nxt  = r_we;
        end
      end
      S_DONE: begin
        if (r_winner == PTR_W'(NUM_REQ - 1)) w_ptr_nxt = '0;
        else                                 w_ptr_nxt = r_winner + 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_winner <= '0;
      r_we     <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_oe     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_winner <= w_winner_nxt;
      r_we     <= w_we_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_mrd    <= w_mrd_nxt;
      r_mwr    <= w_mwr_nxt;
      r_oe     <= w_oe_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_data_oe = r_oe;
  assign mrd         = r_mrd;
  assign mwr         = r_mwr;

endmodule
